window_line_buffer: RTL

//   Raster-scan 3x3 window generator for the image filter engine. Reads the 128x128 source

---
 rtl/window_line_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/window_line_buffer.sv
// Raster 3x3 window generator: streams a 128x128 image from ROM, emits zero-padded windows plus their sum.
// Latency: start -> first window after IMG_W+3 cycles, then one window per cycle while win_ready is high.
// Backpressure: win_valid & ~win_ready freezes ROM fetch, shift register, counters and all window outputs.
module window_line_buffer #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AW-1:0]   iaddr,
  input  logic [DW-1:0]   idata,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [AW-1:0]   win_addr,
  output logic [9*DW-1:0] win_data,
  output logic [11:0]     win_sum,
  output logic            busy,
  output logic            done
);

  localparam int LW   = $clog2(IMG_W);
  localparam int NSR  = 2 * IMG_W + 3;
  localparam int NPIX = IMG_W * IMG_H;

  localparam logic [AW-1:0] FILL_LAST = AW'(IMG_W + 1);
  localparam logic [AW-1:0] PIX_LAST  = AW'(NPIX - 1);
  localparam logic [AW-1:0] BOT_FIRST = AW'(NPIX - IMG_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] f_q, f_d;   // fetch address of the next pixel to capture
  logic [AW-1:0] c_q, c_d;   // raster address of the current window centre
  logic [DW-1:0] sr_q [NSR];
  logic [DW-1:0] sr_d [NSR];

  logic          advance;
  logic          valid_int;
  logic [DW-1:0] tap [9];
  logic          top_row, bot_row, left_col, right_col;
  logic [11:0]   sum_acc;

  assign valid_int = (state_q == S_STREAM) || (state_q == S_FLUSH);
  assign advance   = ~(valid_int & ~win_ready);

  // Next-state logic: FSM, fetch/centre counters and the line shift register
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    c_d     = c_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          f_d     = '0;
          c_d     = '0;
        end
      end
      S_FILL, S_STREAM: begin
        if (advance) begin
          for (int i = NSR - 1; i > 0; i--) sr_d[i] = sr_q[i - 1];
          sr_d[0] = idata;
          // Once the final pixel is captured the address parks on it for the flush phase
          if (f_q != PIX_LAST) f_d = f_q + AW'(1);
          if (state_q == S_STREAM) c_d = c_q + AW'(1);
          if (state_q == S_FILL && f_q == FILL_LAST) state_d = S_STREAM;
          if (state_q == S_STREAM && f_q == PIX_LAST) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (advance) begin
          for (int i = NSR - 1; i > 0; i--) sr_d[i] = sr_q[i - 1];
          sr_d[0] = '0;
          if (c_q == PIX_LAST) state_d = S_DONE;
          else                 c_d     = c_q + AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        f_d     = '0;
        c_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      c_q     <= '0;
      for (int i = 0; i < NSR; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      c_q     <= c_d;
      for (int i = 0; i < NSR; i++) sr_q[i] <= sr_d[i];
    end
  end

  assign top_row   = (c_q < AW'(IMG_W));
  assign bot_row   = (c_q >= BOT_FIRST);
  assign left_col  = (c_q[LW-1:0] == '0);
  assign right_col = (c_q[LW-1:0] == '1);

  // Pick the nine taps (p11..p33), zero the ones that fall outside the image, and sum them
  always_comb begin
    tap[0] = sr_q[2*IMG_W+2];
    tap[1] = sr_q[2*IMG_W+1];
    tap[2] = sr_q[2*IMG_W];
    tap[3] = sr_q[IMG_W+2];
    tap[4] = sr_q[IMG_W+1];
    tap[5] = sr_q[IMG_W];
    tap[6] = sr_q[2];
    tap[7] = sr_q[1];
    tap[8] = sr_q[0];
    for (int i = 0; i < 9; i++) begin
      if ((i / 3 == 0 && top_row) || (i / 3 == 2 && bot_row) ||
          (i % 3 == 0 && left_col) || (i % 3 == 2 && right_col) || !valid_int)
        tap[i] = '0;
    end
    sum_acc = '0;
    for (int i = 0; i < 9; i++) sum_acc = sum_acc + 12'(tap[i]);
  end

  assign iaddr     = f_q;
  assign win_valid = valid_int;
  assign win_addr  = c_q;
  assign win_data  = {tap[0], tap[1], tap[2], tap[3], tap[4], tap[5], tap[6], tap[7], tap[8]};
  assign win_sum   = sum_acc;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
